event_scheduler: RTL and testbench
==================================

Name: event_scheduler

Overview:
- Sits between the two event sources and the neuron-update controller: the sensor input FIFO and the recurrent spike FIFO, whose entries are the spike addresses of the PE array.
- Pops one event at a time from the selected FIFO and presents it to the controller as a held request. Waits for the controller's completion handshake before popping the next event.
- Arbitrates round-robin between the two sources and enforces timestep boundaries. On a boundary it stops issuing events and emits a one-cycle sync pulse.

Parameters:
ADDR_W, 4, event/neuron address width (16 neurons)
CNT_W, 8, width of the per-timestep event counter

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
sens_empty  in  1  sensor FIFO empty
sens_ren  out  1  sensor FIFO read enable
sens_addr  in  ADDR_W  sensor FIFO data out
rec_empty  in  1  recurrent FIFO empty
rec_ren  out  1  recurrent FIFO read enable
rec_addr  in  ADDR_W  recurrent FIFO data out
rec_enable  in  1  allow recurrent events to be granted
event_received  out  1  event request to controller, held until done
event_addr  out  ADDR_W  address of the issued event
event_src  out  1  source of the issued event: 0 = sensor, 1 = recurrent
event_done  in  1  controller finished the current event (1-cycle pulse)
ts_tick  in  1  timestep boundary request (pulse)
ts_sync  out  1  one-cycle timestep sync pulse
ts_events  out  CNT_W  events completed in the last closed timestep
ts_overrun  out  1  one-cycle pulse: tick arrived while one was already pending
busy  out  1  state != IDLE

Behaviour:
- FIFO contract: dout is valid the cycle after ren is high, with 1-cycle read latency. A source is eligible when its empty input is 0.
- Reset (async assert, sync release):
  - State is IDLE.
  - All outputs are 0, including event_addr, event_src and ts_events.
  - The tick_pending flag is cleared and the event counter is 0.
  - last_grant is set to recurrent, so sensor wins the first tie.
  - Reset mid-event abandons the event. An entry already popped is lost; this is accepted.
- States: IDLE, RD, CAP, ISSUE, SYNC.
- IDLE:
  - If tick_pending is set, go to SYNC. Ticks have priority over events.
  - Otherwise, if exactly one source is eligible (recurrent also requires rec_enable=1), grant it.
  - If both are eligible, grant the source not in last_grant.
  - On a grant, update last_grant and the src register, then go to RD.
  - If no source is eligible, stay in IDLE.
- RD: assert the granted source's ren for exactly one cycle, then go to CAP. The other ren stays 0.
- CAP:
  - Register the selected FIFO dout into event_addr and src into event_src.
  - Set event_received=1 for the next cycle, then go to ISSUE.
- ISSUE:
  - event_received=1; event_addr and event_src are held stable.
  - On event_done=1: event_received=0 next cycle, the event counter increments (saturating at 2^CNT_W-1), and the state goes to IDLE.
- event_done outside ISSUE is ignored.
- Latency:
  - Source eligible in IDLE at cycle 0: ren high in cycle 1, event_received high from cycle 3.
  - event_done in cycle N: next ren at earliest in cycle N+2.
- ts_tick handling:
  - ts_tick=1 in any state sets tick_pending. An in-flight event always completes first.
  - ts_tick while tick_pending is already set gives a ts_overrun pulse; the ticks coalesce into one.
- SYNC:
  - ts_sync=1 for one cycle, and ts_events is loaded with the counter value.
  - The counter is cleared and tick_pending is cleared, then the state goes to IDLE.
  - ts_tick in the SYNC cycle re-sets tick_pending as a new boundary; it is not an overrun.
- rec_enable=0: rec_ren is never asserted and recurrent entries stay in their FIFO. Deasserting rec_enable mid-event does not affect the current event.
- busy = (state != IDLE). event_received and ren are never high in the same cycle.

Test Plan:
- Single sensor event: sens_empty=0 with sens_addr=4'd5, rec_empty=1 → sens_ren high in cycle 1 only; event_received high from cycle 3 with event_addr=5, event_src=0. event_done at cycle 6 → event_received low at cycle 7, busy low.
- Round-robin: both FIFOs non-empty, rec_enable=1, immediate event_done each time → event_src sequence 0,1,0,1.
- rec_enable gating: with rec_enable=0, four events are served and all have event_src=0. rec_ren stays 0 until rec_enable rises, and the next tie is granted to recurrent.
- Tick during event: ts_tick in ISSUE after 3 completed events → the current event finishes, then ts_sync pulses with ts_events=4. No ren between event_done and ts_sync, and the counter restarts at 0.
- Overrun and coalescing: two ts_tick pulses during one ISSUE → ts_overrun pulses once and exactly one ts_sync follows.
- Reset mid-operation: assert reset_n=0 in ISSUE → event_received, ren and ts_sync are 0 immediately (asynchronously). After release, with both FIFOs non-empty, sensor is granted first.

Source files
------------

// File: rtl/event_scheduler.sv
// Round-robin event scheduler between the sensor and recurrent spike FIFOs.
// Issues one held event at a time to the neuron controller and closes timesteps.
module event_scheduler #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sens_empty,
  output logic              sens_ren,
  input  logic [ADDR_W-1:0] sens_addr,
  input  logic              rec_empty,
  output logic              rec_ren,
  input  logic [ADDR_W-1:0] rec_addr,
  input  logic              rec_enable,
  output logic              event_received,
  output logic [ADDR_W-1:0] event_addr,
  output logic              event_src,
  input  logic              event_done,
  input  logic              ts_tick,
  output logic              ts_sync,
  output logic [CNT_W-1:0]  ts_events,
  output logic              ts_overrun,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    ISSUE,
    SYNC
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_last;
  logic               r_src;
  logic               r_pend;
  logic               r_ovr;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_esrc;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_ts_events;
  logic               w_sens_ok;
  logic               w_rec_ok;
  logic               w_grant;
  logic               w_gsrc;
  logic               w_take;

  assign w_sens_ok = !sens_empty;
  assign w_rec_ok  = !rec_empty && rec_enable;

  // Tie goes to the source that did not win last time
  always_comb begin
    w_grant = 1'b0;
    w_gsrc  = r_src;
    unique case (1'b1)
      (w_sens_ok && w_rec_ok): begin
        w_grant = 1'b1;
        w_gsrc  = ~r_last;
      end
      (w_sens_ok && !w_rec_ok): begin
        w_grant = 1'b1;
        w_gsrc  = 1'b0;
      end
      (!w_sens_ok && w_rec_ok): begin
        w_grant = 1'b1;
        w_gsrc  = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_take = (r_state == IDLE) && !r_pend && w_grant;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (r_pend)
          w_next = SYNC;
        else if (w_grant)
          w_next = RD;
      end
      RD:    w_next = CAP;
      CAP:   w_next = ISSUE;
      ISSUE: begin
        if (event_done)
          w_next = IDLE;
      end
      SYNC:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_src       <= 1'b0;
      r_pend      <= 1'b0;
      r_ovr       <= 1'b0;
      r_addr      <= '0;
      r_esrc      <= 1'b0;
      r_cnt       <= '0;
      r_ts_events <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_last <= w_gsrc;
        r_src  <= w_gsrc;
      end
      if (r_state == CAP) begin
        r_addr <= r_src ? rec_addr : sens_addr;
        r_esrc <= r_src;
      end
      if (r_state == ISSUE && event_done && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
      else if (r_state == SYNC)
        r_cnt <= '0;
      if (r_state == IDLE && r_pend)
        r_ts_events <= r_cnt;
      // A tick landing in SYNC opens the next boundary
      if (ts_tick)
        r_pend <= 1'b1;
      else if (r_state == SYNC)
        r_pend <= 1'b0;
      r_ovr <= ts_tick && r_pend && (r_state != SYNC);
    end
  end

  assign sens_ren       = (r_state == RD) && !r_src;
  assign rec_ren        = (r_state == RD) && r_src;
  assign event_received = (r_state == ISSUE);
  assign event_addr     = r_addr;
  assign event_src      = r_esrc;
  assign ts_sync        = (r_state == SYNC);
  assign ts_events      = r_ts_events;
  assign ts_overrun     = r_ovr;
  assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_event_scheduler.sv
// Directed bench for event_scheduler with simple FIFO models on both sources.
module tb_event_scheduler;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       sens_empty;
  logic       sens_ren;
  logic [3:0] sens_addr = '0;
  logic       rec_empty;
  logic       rec_ren;
  logic [3:0] rec_addr = '0;
  logic       rec_enable = 1'b1;
  logic       event_received;
  logic [3:0] event_addr;
  logic       event_src;
  logic       event_done = 1'b0;
  logic       ts_tick = 1'b0;
  logic       ts_sync;
  logic [7:0] ts_events;
  logic       ts_overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [3:0] sens_mem [64];
  logic [3:0] rec_mem  [64];
  int sens_wr = 0;
  int sens_rd = 0;
  int rec_wr  = 0;
  int rec_rd  = 0;

  int n_sync = 0;
  int n_ovr = 0;
  int n_rec_bad = 0;
  int n_ren = 0;

  always #5 clock = ~clock;

  event_scheduler dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .sens_empty     (sens_empty),
    .sens_ren       (sens_ren),
    .sens_addr      (sens_addr),
    .rec_empty      (rec_empty),
    .rec_ren        (rec_ren),
    .rec_addr       (rec_addr),
    .rec_enable     (rec_enable),
    .event_received (event_received),
    .event_addr     (event_addr),
    .event_src      (event_src),
    .event_done     (event_done),
    .ts_tick        (ts_tick),
    .ts_sync        (ts_sync),
    .ts_events      (ts_events),
    .ts_overrun     (ts_overrun),
    .busy           (busy)
  );

  assign sens_empty = (sens_wr == sens_rd);
  assign rec_empty  = (rec_wr == rec_rd);

  // 1-cycle read latency FIFO models
  always @(posedge clock) begin
    if (sens_ren && sens_rd != sens_wr) begin
      sens_addr <= sens_mem[sens_rd];
      sens_rd   <= sens_rd + 1;
    end
    if (rec_ren && rec_rd != rec_wr) begin
      rec_addr <= rec_mem[rec_rd];
      rec_rd   <= rec_rd + 1;
    end
  end

  always @(negedge clock) begin
    if (ts_sync) n_sync++;
    if (ts_overrun) n_ovr++;
    if (rec_ren && !rec_enable) n_rec_bad++;
    if (sens_ren || rec_ren) n_ren++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_s(input logic [3:0] a);
    sens_mem[sens_wr] = a;
    sens_wr++;
  endtask

  task automatic push_r(input logic [3:0] a);
    rec_mem[rec_wr] = a;
    rec_wr++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_ev(input string tag);
    int n;
    n = 0;
    while (!event_received && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 32'(event_received), 1);
  endtask

  task automatic serve(input string tag, input logic s,
                       input logic [3:0] a);
    wait_ev(tag);
    chk({tag, "_src"}, 32'(event_src), 32'(s));
    chk({tag, "_addr"}, 32'(event_addr), 32'(a));
    event_done = 1'b1;
    step();
    event_done = 1'b0;
  endtask

  int base_sync;
  int base_ovr;
  int base_ren;

  initial begin
    // reset state
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_evrx", 32'(event_received), 0);
    chk("rst_addr", 32'(event_addr), 0);
    chk("rst_src", 32'(event_src), 0);
    chk("rst_tsev", 32'(ts_events), 0);
    chk("rst_sync", 32'(ts_sync), 0);
    chk("rst_ren", 32'({sens_ren, rec_ren}), 0);
    reset_n = 1'b1;
    step();

    // single sensor event, cycle-accurate
    push_s(4'd5);
    step();
    chk("t1_c1_sren", 32'(sens_ren), 1);
    chk("t1_c1_rren", 32'(rec_ren), 0);
    chk("t1_c1_busy", 32'(busy), 1);
    step();
    chk("t1_c2_sren", 32'(sens_ren), 0);
    chk("t1_c2_evrx", 32'(event_received), 0);
    step();
    chk("t1_c3_evrx", 32'(event_received), 1);
    chk("t1_c3_addr", 32'(event_addr), 5);
    chk("t1_c3_src", 32'(event_src), 0);
    step();
    step();
    step();
    chk("t1_c6_evrx", 32'(event_received), 1);
    chk("t1_c6_addr", 32'(event_addr), 5);
    event_done = 1'b1;
    step();
    event_done = 1'b0;
    chk("t1_c7_evrx", 32'(event_received), 0);
    chk("t1_c7_busy", 32'(busy), 0);

    // round-robin
    do_reset();
    push_s(4'd1);
    push_s(4'd2);
    push_r(4'd9);
    push_r(4'd10);
    serve("rr0", 1'b0, 4'd1);
    serve("rr1", 1'b1, 4'd9);
    serve("rr2", 1'b0, 4'd2);
    serve("rr3", 1'b1, 4'd10);

    // rec_enable gating
    do_reset();
    rec_enable = 1'b0;
    push_r(4'd7);
    for (int i = 1; i <= 4; i++) push_s(4'(i));
    serve("g0", 1'b0, 4'd1);
    serve("g1", 1'b0, 4'd2);
    serve("g2", 1'b0, 4'd3);
    serve("g3", 1'b0, 4'd4);
    chk("g_recren", 32'(n_rec_bad), 0);
    chk("g_recheld", 32'(rec_empty), 0);
    push_s(4'd5);
    rec_enable = 1'b1;
    serve("g4", 1'b1, 4'd7);
    serve("g5", 1'b0, 4'd5);

    // tick during an event after 3 completions
    do_reset();
    for (int i = 1; i <= 10; i++) push_s(4'(i));
    serve("k0", 1'b0, 4'd1);
    serve("k1", 1'b0, 4'd2);
    serve("k2", 1'b0, 4'd3);
    wait_ev("k3");
    ts_tick = 1'b1;
    step();
    ts_tick = 1'b0;
    chk("k3_evrx", 32'(event_received), 1);
    chk("k3_sync0", 32'(ts_sync), 0);
    base_ren = n_ren;
    event_done = 1'b1;
    step();
    event_done = 1'b0;
    chk("k_done_sync", 32'(ts_sync), 0);
    chk("k_done_ren", 32'({sens_ren, rec_ren}), 0);
    step();
    chk("k_sync", 32'(ts_sync), 1);
    chk("k_tsev", 32'(ts_events), 4);
    chk("k_noren", 32'(n_ren - base_ren), 0);
    step();
    chk("k_sync_1cyc", 32'(ts_sync), 0);
    serve("k4", 1'b0, 4'd5);
    wait_ev("k5");
    ts_tick = 1'b1;
    step();
    ts_tick = 1'b0;
    event_done = 1'b1;
    step();
    event_done = 1'b0;
    step();
    chk("k_sync2", 32'(ts_sync), 1);
    chk("k_tsev2", 32'(ts_events), 2);

    // overrun and coalescing
    wait_ev("o0");
    chk("o0_addr", 32'(event_addr), 7);
    base_sync = n_sync;
    base_ovr = n_ovr;
    ts_tick = 1'b1;
    step();
    chk("o_no_ovr1", 32'(ts_overrun), 0);
    step();
    ts_tick = 1'b0;
    chk("o_ovr", 32'(ts_overrun), 1);
    event_done = 1'b1;
    step();
    event_done = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("o_ovr_cnt", 32'(n_ovr - base_ovr), 1);
    chk("o_sync_cnt", 32'(n_sync - base_sync), 1);
    chk("o_tsev", 32'(ts_events), 1);

    // reset mid-event
    wait_ev("r0");
    chk("r0_addr", 32'(event_addr), 8);
    reset_n = 1'b0;
    #1;
    chk("r_evrx", 32'(event_received), 0);
    chk("r_ren", 32'({sens_ren, rec_ren}), 0);
    chk("r_sync", 32'(ts_sync), 0);
    chk("r_busy", 32'(busy), 0);
    push_r(4'd11);
    step();
    step();
    reset_n = 1'b1;
    serve("r1", 1'b0, 4'd9);
    serve("r2", 1'b1, 4'd11);
    serve("r3", 1'b0, 4'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
